// File: rtl/popcount_arbiter.sv
// Round-robin shared serial popcount engine: one bit per clock, NREQ requesters.
// Optional macro POPCOUNT_EARLY_TERM_EN ends counting once the remaining shift bits are zero.
module popcount_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = $clog2(WIDTH + 1),
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  i_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic [CW-1:0]          no_ones,
  output logic                   done,
  output logic [IDW-1:0]         done_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    acc_q;
  logic [CW-1:0]    bitcnt_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   win_q;

  logic             pick_valid_c;
  logic [IDW-1:0]   pick_id_c;
  logic [WIDTH-1:0] pick_word_c;
  logic [IDW-1:0]   next_ptr_c;
  logic             last_bit_c;

  // Round-robin search: first pass from ptr upward, second pass wraps to the bottom.
  always_comb begin
    pick_valid_c = 1'b0;
    pick_id_c    = '0;
    pick_word_c  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!pick_valid_c && req[k] && (IDW'(k) >= ptr_q)) begin
        pick_valid_c = 1'b1;
        pick_id_c    = IDW'(k);
        pick_word_c  = i_data[k*WIDTH +: WIDTH];
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!pick_valid_c && req[k]) begin
        pick_valid_c = 1'b1;
        pick_id_c    = IDW'(k);
        pick_word_c  = i_data[k*WIDTH +: WIDTH];
      end
    end
    next_ptr_c = (pick_id_c == IDW'(NREQ - 1)) ? '0 : pick_id_c + IDW'(1);
  end

`ifdef POPCOUNT_EARLY_TERM_EN
  assign last_bit_c = (bitcnt_q == CW'(WIDTH - 1)) || ((shift_q >> 1) == '0);
`else
  assign last_bit_c = (bitcnt_q == CW'(WIDTH - 1));
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      gnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      no_ones  <= '0;
      done_id  <= '0;
      shift_q  <= '0;
      acc_q    <= '0;
      bitcnt_q <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (pick_valid_c) begin
            gnt      <= NREQ'(1) << pick_id_c;
            busy     <= 1'b1;
            shift_q  <= pick_word_c;
            acc_q    <= '0;
            bitcnt_q <= '0;
            win_q    <= pick_id_c;
            ptr_q    <= next_ptr_c;
            state    <= S_COUNT;
          end
        end
        S_COUNT: begin
          acc_q    <= acc_q + CW'(shift_q[0]);
          shift_q  <= shift_q >> 1;
          bitcnt_q <= bitcnt_q + CW'(1);
          if (last_bit_c) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          no_ones <= acc_q;
          done_id <= win_q;
          gnt     <= '0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_arbiter.sv
// Self-checking bench for popcount_arbiter: transaction-level model compared every cycle
// plus directed vectors with hand-computed counts and latencies.
module tb_popcount_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 16;

`ifdef POPCOUNT_EARLY_TERM_EN
  localparam int LAT_ZERO = 3;
  localparam int LAT_0010 = 7;
`else
  localparam int LAT_ZERO = 18;
  localparam int LAT_0010 = 18;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] i_data;
  logic [3:0]  gnt;
  logic        busy;
  logic [4:0]  no_ones;
  logic        done;
  logic [1:0]  done_id;

  int checks = 0;
  int errors = 0;

  popcount_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req(req), .i_data(i_data),
    .gnt(gnt), .busy(busy), .no_ones(no_ones), .done(done), .done_id(done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of serial cycles the engine spends on a word.
  function automatic int count_cycles(input logic [15:0] w);
`ifdef POPCOUNT_EARLY_TERM_EN
    int n;
    n = 1;
    for (int i = 0; i < 16; i++) if (w[i]) n = i + 1;
    return n;
`else
    return WIDTH;
`endif
  endfunction

  // Transaction model: each grant runs count_cycles+1 edges, then a one-cycle done.
  bit          m_run;
  int          m_left;
  int          m_win;
  int          m_ptr;
  int          m_exp;
  bit          m_done;
  int          m_cnt;
  int          m_done_id;
  logic [15:0] m_word;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_left = 0; m_win = 0; m_ptr = 0; m_exp = 0;
      m_done = 0; m_cnt = 0; m_done_id = 0; m_word = '0;
    end else begin
      m_done = 0;
      if (m_run) begin
        m_left--;
        if (m_left == 0) begin
          m_run = 0; m_done = 1; m_cnt = m_exp; m_done_id = m_win;
        end
      end else if (req != 4'b0) begin
        bit found;
        found = 0;
        for (int i = 0; i < NREQ; i++) begin
          int c;
          c = (m_ptr + i) % NREQ;
          if (!found && req[c]) begin found = 1; m_win = c; end
        end
        m_word = i_data[m_win*16 +: 16];
        m_exp  = $countones(m_word);
        m_left = count_cycles(m_word) + 1;
        m_run  = 1;
        m_ptr  = (m_win + 1) % NREQ;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("gnt", 32'(gnt), m_run ? (32'd1 << m_win) : 32'd0);
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("no_ones", 32'(no_ones), 32'(m_cnt));
      chk("done_id", 32'(done_id), 32'(m_done_id));
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 100);
    if (!done) chk("done_timeout", 32'(lat), 32'd0);
  endtask

  task automatic run_one(input int id, input logic [15:0] word, input int exp_cnt,
                         input int exp_lat, input logic [3:0] exp_gnt);
    int lat;
    @(negedge clk);
    i_data[id*16 +: 16] = word;
    req[id] = 1'b1;
    @(negedge clk);
    chk("gnt_after_req", 32'(gnt), 32'(exp_gnt));
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 32'(lat), 32'd0);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("count", 32'(no_ones), 32'(exp_cnt));
    chk("id", 32'(done_id), 32'(id));
    req[id] = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    int exp_ids [5] = '{0, 1, 2, 3, 0};
    int exp_cnts[5] = '{1, 2, 3, 4, 1};

    reset = 1'b0; req = '0; i_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_no_ones", 32'(no_ones), 32'd0);
    reset = 1'b1;

    run_one(2, 16'hA5A5, 8, 18, 4'b0100);
    chk("model_a5a5", 32'(m_exp), 32'd8);
    run_one(0, 16'hFFFF, 16, 18, 4'b0001);
    run_one(0, 16'h0000, 0, LAT_ZERO, 4'b0001);

    // Word and request change mid-count; original word must be reported.
    @(negedge clk);
    i_data[31:16] = 16'h00FF; req[1] = 1'b1;
    repeat (4) @(negedge clk);
    i_data[31:16] = 16'hFFFF; req[1] = 1'b0;
    wait_done(lat);
    chk("midop_count", 32'(no_ones), 32'd8);
    chk("midop_id", 32'(done_id), 32'd1);

    run_one(3, 16'h0010, 1, LAT_0010, 4'b1000);
    run_one(3, 16'h8001, 2, 18, 4'b1000);
    chk("model_8001", 32'(m_exp), 32'd2);

    // Asynchronous reset in the middle of a count.
    @(negedge clk);
    i_data[63:48] = 16'hFFFF; req[3] = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_no_ones", 32'(no_ones), 32'd0);
    chk("arst_done_id", 32'(done_id), 32'd0);
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no_done_after_reset", 32'(seen), 32'd0);

    // Fairness with all requests held.
    @(negedge clk);
    i_data = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(lat);
      chk("rr_id", 32'(done_id), 32'(exp_ids[n]));
      chk("rr_count", 32'(no_ones), 32'(exp_cnts[n]));
      if (n == 4) begin
        req = '0;
      end else begin
        @(negedge clk);
        chk("rr_next_gnt", 32'(gnt), 32'd1 << ((exp_ids[n] + 1) % 4));
      end
    end
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
